status_led_ctrl: RTL and testbench

//   Parametrised multi-channel status-LED controller for the board top level; generalises the single

---
 rtl/status_led_ctrl.sv | 105 ++++++++++
 tb/tb_status_led_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/status_led_ctrl.sv
// Multi-channel status-LED controller: shared prescaler/blink/PWM timebase, per-channel OFF/PWM/BLINK/PULSE.
// The per-channel event input is named evt because event is a reserved word in SystemVerilog.
module status_led_ctrl #(
    parameter int unsigned NUM_LEDS      = 4,
    parameter int unsigned TICK_DIV      = 125000,
    parameter int unsigned BLINK_TICKS   = 500,
    parameter int unsigned STRETCH_TICKS = 50,
    parameter int unsigned PWM_W         = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [2*NUM_LEDS-1:0]     mode,
    input  logic [PWM_W*NUM_LEDS-1:0] duty,
    input  logic [NUM_LEDS-1:0]       evt,
    output logic [NUM_LEDS-1:0]       led,
    output logic                      tick
);

    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int unsigned STR_W   = $clog2(STRETCH_TICKS + 1);

    localparam logic [1:0] MODE_PWM   = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_PULSE = 2'b11;

    logic [PRESC_W-1:0]               presc;
    logic [BLINK_W-1:0]               blink_cnt;
    logic [BLINK_W-1:0]               blink_cnt_nxt;
    logic                             blink_phase;
    logic                             blink_phase_nxt;
    logic [PWM_W-1:0]                 pwm_cnt;
    logic [NUM_LEDS-1:0][STR_W-1:0]   stretch;
    logic [NUM_LEDS-1:0][STR_W-1:0]   stretch_nxt;
    logic [NUM_LEDS-1:0]              led_nxt;

    // Prescaler and registered tick strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            tick  <= 1'b0;
        end else if (presc == PRESC_W'(TICK_DIV - 1)) begin
            presc <= '0;
            tick  <= 1'b1;
        end else begin
            presc <= presc + PRESC_W'(1);
            tick  <= 1'b0;
        end
    end

    // Blink timebase steps on the registered tick; led follows the next phase so it lands with tick
    always_comb begin
        blink_cnt_nxt   = blink_cnt;
        blink_phase_nxt = blink_phase;
        if (tick) begin
            if (blink_cnt == BLINK_W'(BLINK_TICKS - 1)) begin
                blink_cnt_nxt   = '0;
                blink_phase_nxt = ~blink_phase;
            end else begin
                blink_cnt_nxt = blink_cnt + BLINK_W'(1);
            end
        end
    end

    // Per-channel stretch update and LED select
    always_comb begin
        led_nxt     = '0;
        stretch_nxt = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (mode[2*i +: 2] == MODE_PULSE) begin
                if (evt[i]) begin
                    stretch_nxt[i] = STR_W'(STRETCH_TICKS);
                end else if (tick && (stretch[i] != '0)) begin
                    stretch_nxt[i] = stretch[i] - STR_W'(1);
                end else begin
                    stretch_nxt[i] = stretch[i];
                end
            end
            case (mode[2*i +: 2])
                MODE_PWM:   led_nxt[i] = (duty[PWM_W*i +: PWM_W] == '1) ||
                                         (pwm_cnt < duty[PWM_W*i +: PWM_W]);
                MODE_BLINK: led_nxt[i] = blink_phase_nxt;
                MODE_PULSE: led_nxt[i] = (stretch_nxt[i] != '0);
                default:    led_nxt[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            pwm_cnt     <= '0;
            stretch     <= '0;
            led         <= '0;
        end else begin
            blink_cnt   <= blink_cnt_nxt;
            blink_phase <= blink_phase_nxt;
            pwm_cnt     <= pwm_cnt + PWM_W'(1);
            stretch     <= stretch_nxt;
            led         <= led_nxt;
        end
    end

endmodule

// File: tb/tb_status_led_ctrl.sv
// Directed bench for status_led_ctrl with a scoreboard queue of expected led/tick values.
module tb_status_led_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] mode = '0;
    logic [3:0] duty = '0;
    logic [1:0] evt = '0;
    logic [1:0] led;
    logic       tick;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] led;
        logic [1:0] mask;
        logic       tick;
        bit         tchk;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   cq[$];

    status_led_ctrl #(
        .NUM_LEDS(2), .TICK_DIV(4), .BLINK_TICKS(3), .STRETCH_TICKS(2), .PWM_W(2)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .duty(duty), .evt(evt), .led(led), .tick(tick)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [1:0] el, input logic [1:0] mask, input logic et,
                        input bit tchk, input string tag);
        exp_t e;
        e.led = el; e.mask = mask; e.tick = et; e.tchk = tchk; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        e = sb.pop_front();
        if (e.mask != 2'b00) begin
            total++;
            assert ((led & e.mask) === (e.led & e.mask)) else begin
                bad++;
                $error("FAIL %s led observed=%b expected=%b mask=%b", e.tag, led, e.led, e.mask);
            end
        end
        if (e.tchk) begin
            total++;
            assert (tick === e.tick) else begin
                bad++;
                $error("FAIL %s tick observed=%b expected=%b", e.tag, tick, e.tick);
            end
        end
    endtask

    task automatic cnt_check(input int got, input string tag);
        int e;
        e = cq.pop_front();
        total++;
        assert (got === e) else begin
            bad++;
            $error("FAIL %s count observed=%0d expected=%0d", tag, got, e);
        end
    endtask

    // One clock: queue expectation, advance, check #1 after the edge
    task automatic step(input logic [1:0] el, input logic [1:0] mask, input logic et,
                        input bit tchk, input string tag, input int n);
        push(el, mask, et, tchk, $sformatf("%s@%0d", tag, n));
        @(posedge clk);
        #1;
        sb_check();
    endtask

    // Async reset asserted mid-cycle, checked immediately, released on the next falling edge
    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        push(2'b00, 2'b11, 1'b0, 1'b1, tag);
        #1;
        sb_check();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic bph(input int n);
        return (n >= 1) ? logic'(((n - 1) / 12) % 2) : 1'b0;
    endfunction

    task automatic pulse_run(input int ea, input int eb, input int on_from, input int off_at,
                             input string tag);
        mode = 4'b1100; duty = '0; evt = '0;
        do_reset({tag, "_rst"});
        for (int n = 1; n <= off_at + 3; n++) begin
            step({logic'(n >= on_from && n < off_at), 1'b0}, 2'b11, logic'(n % 4 == 0), 1'b1, tag, n);
            evt = {logic'(n == ea || n == eb), 1'b0};
        end
        evt = '0;
    endtask

    initial begin
        int c0;
        int c1;

        // All channels off: dark LEDs, tick every 4th cycle
        mode = '0;
        do_reset("off_rst");
        for (int n = 1; n <= 16; n++)
            step(2'b00, 2'b11, logic'(n % 4 == 0), 1'b1, "off", n);

        // Blink ch0 from reset, ch1 joins at cycle 30 in phase
        mode = 4'b0010;
        do_reset("blink_rst");
        for (int n = 1; n <= 50; n++) begin
            step({(n >= 31) ? bph(n) : 1'b0, bph(n)}, 2'b11, logic'(n % 4 == 0), 1'b1, "blink", n);
            if (n == 30) mode = 4'b1010;
        end

        // PWM: ch0 duty 1 and ch1 duty 2, counted per 4-cycle window
        mode = 4'b0101; duty = {2'd2, 2'd1};
        do_reset("pwm_rst");
        for (int w = 0; w < 4; w++) begin
            cq.push_back(1);
            cq.push_back(2);
            c0 = 0; c1 = 0;
            for (int k = 0; k < 4; k++) begin
                step(2'b00, 2'b00, 1'b0, 1'b0, "pwm", 4 * w + k + 1);
                c0 += int'(led[0]);
                c1 += int'(led[1]);
            end
            cnt_check(c0, $sformatf("pwm_d1_w%0d", w));
            cnt_check(c1, $sformatf("pwm_d2_w%0d", w));
        end
        // Full duty on ch0, zero duty on ch1
        duty = {2'd0, 2'd3};
        for (int n = 17; n <= 24; n++)
            step(2'b01, 2'b11, 1'b0, 1'b0, "pwm_full_zero", n);

        // Pulse stretch: single event, retrigger, event coincident with tick
        pulse_run(5, 5, 6, 13, "pulse1");
        pulse_run(5, 10, 6, 17, "pulse_ext");
        pulse_run(5, 8, 6, 17, "pulse_tick");

        // Mid-operation mode switches on ch1 while ch0 stays lit at full duty
        mode = 4'b1101; duty = {2'd0, 2'd3}; evt = '0;
        do_reset("midop_rst");
        for (int n = 1; n <= 20; n++) begin
            step({logic'(n >= 6 && n <= 8), 1'b1}, 2'b11, logic'(n % 4 == 0), 1'b1, "midop", n);
            evt = {logic'(n == 5 || n == 9), 1'b0};
            if (n == 8)  mode[3:2] = 2'b00;
            if (n == 10) mode[3:2] = 2'b11;
        end
        evt = '0;

        // Async reset while ch0 lit and tick high, then first tick TICK_DIV cycles later
        do_reset("async_rst");
        for (int n = 1; n <= 8; n++)
            step(2'b01, 2'b11, logic'(n % 4 == 0), 1'b1, "post_rst", n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
